// File: rtl/hub75_col_shifter.sv
// HUB75 column shift engine: streams one bitplane of a row from the line buffer as parallel lane bits.
// Two-cycle read-to-strobe latency; ctrl_go is only accepted while idle (no other backpressure).
module hub75_col_shifter #(
    parameter int N_BANKS  = 2,
    parameter int N_COLS   = 64,
    parameter int N_CHANS  = 3,
    parameter int N_PLANES = 8,
    localparam int CW      = (N_COLS > 1) ? $clog2(N_COLS) : 1,
    localparam int NL      = N_BANKS * N_CHANS
) (
    input  logic                   clk,
    input  logic                   rst,
    output logic [NL-1:0]          phy_data,
    output logic                   phy_clk,
    input  logic [NL*N_PLANES-1:0] ram_data,
    output logic [CW-1:0]          ram_col_addr,
    output logic                   ram_rden,
    input  logic [N_PLANES-1:0]    ctrl_plane,
    input  logic                   ctrl_go,
    output logic                   ctrl_rdy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_col;
    logic [N_PLANES-1:0]   r_plane;
    logic                  r_rden_d1;
    logic                  r_phy_clk;
    logic [NL-1:0]         r_phy_data;
    logic                  w_go_acc;
    logic                  w_rden;
    logic                  w_last_col;
    logic [NL-1:0]         w_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // DRAIN ends on the cycle carrying the final strobe, so ready rises right after it.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (ctrl_go) w_state_nxt = S_READ;
            S_READ:  if (w_last_col) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_phy_clk && !r_rden_d1) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_rden   = 1'b0;
        ctrl_rdy = 1'b0;
        case (r_state)
            S_IDLE:  ctrl_rdy = 1'b1;
            S_READ:  w_rden   = 1'b1;
            default: ;
        endcase
    end

    assign w_go_acc   = (r_state == S_IDLE) && ctrl_go;
    assign w_last_col = (r_col == CW'(N_COLS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col   <= '0;
            r_plane <= '0;
        end else if (w_go_acc) begin
            r_col   <= '0;
            r_plane <= ctrl_plane;
        end else if (w_rden && !w_last_col) begin
            r_col   <= r_col + 1'b1;
        end
    end

    always_comb begin
        w_sel = '0;
        for (int k = 0; k < NL; k++) begin
            w_sel[k] = |(ram_data[k*N_PLANES +: N_PLANES] & r_plane);
        end
    end

    // Data register only loads on valid columns so the last word stays on the bus between rows.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rden_d1  <= 1'b0;
            r_phy_clk  <= 1'b0;
            r_phy_data <= '0;
        end else begin
            r_rden_d1 <= w_rden;
            r_phy_clk <= r_rden_d1;
            if (r_rden_d1) begin
                r_phy_data <= w_sel;
            end
        end
    end

    assign ram_rden     = w_rden;
    assign ram_col_addr = r_col;
    assign phy_clk      = r_phy_clk;
    assign phy_data     = r_phy_data;

endmodule

// File: tb/tb_hub75_col_shifter.sv
// Directed bench for hub75_col_shifter with a registered line-buffer model and a strobe scoreboard.
module tb_hub75_col_shifter;

    logic        clk;
    logic        rst;
    logic [5:0]  phy_data;
    logic        phy_clk;
    logic [47:0] ram_data;
    logic [47:0] ram_next;
    logic [5:0]  ram_col_addr;
    logic        ram_rden;
    logic [7:0]  ctrl_plane;
    logic        ctrl_go;
    logic        ctrl_rdy;

    int          total;
    int          bad;
    int          cyc;
    int          n_rd;
    int          n_pulse;
    int          exp_addr;
    bit          mon_en;
    int          tb_mode;
    logic [7:0]  tb_plane;
    logic [5:0]  addr_q[$];
    int          cyc_q[$];

    hub75_col_shifter dut (
        .clk          (clk),
        .rst          (rst),
        .phy_data     (phy_data),
        .phy_clk      (phy_clk),
        .ram_data     (ram_data),
        .ram_col_addr (ram_col_addr),
        .ram_rden     (ram_rden),
        .ctrl_plane   (ctrl_plane),
        .ctrl_go      (ctrl_go),
        .ctrl_rdy     (ctrl_rdy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Line buffer: lane k holds column bit k in plane tb_mode and its inverse in plane 7.
    always_comb begin
        ram_next = '0;
        for (int k = 0; k < 6; k++) begin
            ram_next[k*8 + tb_mode] = ram_col_addr[k];
            ram_next[k*8 + 7]       = ~ram_col_addr[k];
        end
    end

    always @(posedge clk) begin
        if (ram_rden) ram_data <= ram_next;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [5:0] exp_data(input logic [5:0] col);
        logic [5:0] r;
        for (int k = 0; k < 6; k++) begin
            r[k] = (tb_plane[tb_mode] & col[k]) | (tb_plane[7] & ~col[k]);
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            if (ram_rden) begin
                chk("rd_addr", 64'(ram_col_addr), 64'(exp_addr));
                exp_addr = (exp_addr + 1) % 64;
                addr_q.push_back(ram_col_addr);
                cyc_q.push_back(cyc);
                n_rd++;
            end
            if (phy_clk) begin
                if (addr_q.size() == 0) begin
                    chk("orphan_pulse", 64'd1, 64'd0);
                end else begin
                    logic [5:0] a;
                    int c;
                    a = addr_q.pop_front();
                    c = cyc_q.pop_front();
                    chk("phy_data", 64'(phy_data), 64'(exp_data(a)));
                    chk("phy_lat", 64'(cyc - c), 64'd2);
                end
                n_pulse++;
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic do_row(input logic [7:0] pl, input int glitch_at);
        int start;
        bit done;
        tick();
        chk("rdy_idle", 64'(ctrl_rdy), 64'd1);
        tb_plane   = pl;
        ctrl_plane = pl;
        ctrl_go    = 1'b1;
        n_rd = 0; n_pulse = 0; exp_addr = 0;
        start = cyc;
        tick();
        ctrl_go = 1'b0;
        chk("rdy_drop", 64'(ctrl_rdy), 64'd0);
        done = 0;
        for (int i = 2; i < 200 && !done; i++) begin
            tick();
            if (ctrl_rdy) done = 1;
            if (i == glitch_at) begin
                ctrl_go    = 1'b1;
                ctrl_plane = 8'hFF;
            end else begin
                ctrl_go    = 1'b0;
                ctrl_plane = pl;
            end
        end
        if (!done) chk("row_timeout", 64'd0, 64'd1);
        chk("busy_len", 64'(cyc - start), 64'd67);
        chk("n_rd", 64'(n_rd), 64'd64);
        chk("n_pulse", 64'(n_pulse), 64'd64);
        chk("phy_hold", 64'(phy_data), 64'(exp_data(6'd63)));
        chk("phy_clk_idle", 64'(phy_clk), 64'd0);
    endtask

    task automatic do_b2b();
        int start;
        int rdy_hi;
        bit done;
        tick();
        tb_plane   = 8'h01;
        ctrl_plane = 8'h01;
        ctrl_go    = 1'b1;
        n_rd = 0; n_pulse = 0; exp_addr = 0;
        start = cyc; rdy_hi = 0; done = 0;
        for (int i = 1; i < 400 && !done; i++) begin
            tick();
            if (ctrl_rdy) rdy_hi++;
            if (n_pulse == 192) done = 1;
        end
        ctrl_go = 1'b0;
        if (!done) chk("b2b_timeout", 64'd0, 64'd1);
        chk("b2b_span", 64'(cyc - start), 64'd200);
        chk("b2b_rdy_gaps", 64'(rdy_hi), 64'd2);
        chk("b2b_n_rd", 64'(n_rd), 64'd192);
        tick();
        chk("b2b_rdy_end", 64'(ctrl_rdy), 64'd1);
        chk("b2b_n_pulse", 64'(n_pulse), 64'd192);
    endtask

    task automatic do_abort();
        bit found;
        tick();
        tb_plane   = 8'h01;
        ctrl_plane = 8'h01;
        ctrl_go    = 1'b1;
        exp_addr   = 0;
        tick();
        ctrl_go = 1'b0;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (ram_rden && ram_col_addr == 6'd20) found = 1;
            else tick();
        end
        if (!found) chk("abort_timeout", 64'd0, 64'd1);
        chk("abort_phy_pre", 64'(phy_data), 64'h12);
        mon_en = 0;
        rst    = 1'b1;
        tick();
        chk("abort_rden", 64'(ram_rden), 64'd0);
        chk("abort_phy_clk", 64'(phy_clk), 64'd0);
        chk("abort_phy_data", 64'(phy_data), 64'd0);
        rst = 1'b0;
        addr_q.delete();
        cyc_q.delete();
        tick();
        chk("abort_rdy", 64'(ctrl_rdy), 64'd1);
        chk("abort_addr", 64'(ram_col_addr), 64'd0);
        mon_en = 1;
        do_row(8'h01, 0);
    endtask

    initial begin
        total = 0; bad = 0; cyc = 0;
        n_rd = 0; n_pulse = 0; exp_addr = 0;
        mon_en = 0; tb_mode = 0; tb_plane = 8'h00;
        ram_data = '0;
        rst = 1'b1; ctrl_go = 1'b0; ctrl_plane = 8'h00;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_rdy", 64'(ctrl_rdy), 64'd1);
        chk("rst_rden", 64'(ram_rden), 64'd0);
        chk("rst_phy_clk", 64'(phy_clk), 64'd0);
        chk("rst_phy_data", 64'(phy_data), 64'd0);
        chk("rst_addr", 64'(ram_col_addr), 64'd0);
        mon_en = 1;

        tb_mode = 0; do_row(8'h01, 0);
        tb_mode = 0; do_row(8'h02, 0);
        tb_mode = 1; do_row(8'h02, 0);
        tb_mode = 0; do_row(8'h81, 0);
        tb_mode = 0; do_row(8'h00, 0);
        tb_mode = 0; do_row(8'h01, 30);
        do_b2b();
        do_abort();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
